// File: rtl/seq_divider_if.sv
// seq_divider_if: issue-side operand handshake and writeback-side result handshake
// for the sequential divider. The divider itself uses the slave modport.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define SEQ_DIV_EARLY_OUT_EN to compile in the |a| < |b| single-cycle early-out.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kill,
  output logic         busy,
  seq_divider_if.slave dif
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Shared adder/subtractor: x - y with Cin=1; top bit is Carry (1 = no borrow).
  function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    add_sub = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    negate = ~x + ONE;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [1:0]       op_r, op_nxt_s;
  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;
  logic             sign_a_r, sign_a_nxt_s;
  logic             sign_b_r, sign_b_nxt_s;
  logic [WIDTH-1:0] rem_r, rem_nxt_s;
  logic [WIDTH-1:0] quo_r, quo_nxt_s;
  logic [WIDTH-1:0] dvs_r, dvs_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic             in_ready_r, out_valid_r, busy_r;

  logic [WIDTH-1:0] rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic             no_borrow_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [WIDTH-1:0] quo_fix_s, rem_fix_s;
  logic             is_signed_s;

  // Next-state and datapath next values; kill overrides every state.
  always_comb begin
    state_nxt_s  = state_r;
    op_nxt_s     = op_r;
    a_nxt_s      = a_r;
    b_nxt_s      = b_r;
    sign_a_nxt_s = sign_a_r;
    sign_b_nxt_s = sign_b_r;
    rem_nxt_s    = rem_r;
    quo_nxt_s    = quo_r;
    dvs_nxt_s    = dvs_r;
    cnt_nxt_s    = cnt_r;
    result_nxt_s = result_r;

    // The bit shifted out of rem guarantees no borrow even when the adder wraps.
    rem_sh_s    = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
    trial_s     = add_sub(rem_sh_s, dvs_r);
    no_borrow_s = trial_s[WIDTH] | rem_r[WIDTH-1];
    abs_a_s     = sign_a_r ? negate(a_r) : a_r;
    abs_b_s     = sign_b_r ? negate(b_r) : b_r;
    quo_fix_s   = (sign_a_r ^ sign_b_r) ? negate(quo_r) : quo_r;
    rem_fix_s   = sign_a_r ? negate(rem_r) : rem_r;
    is_signed_s = ~op_r[0];

    if (kill) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (dif.in_valid & in_ready_r) begin
            op_nxt_s     = dif.op;
            a_nxt_s      = dif.a;
            b_nxt_s      = dif.b;
            sign_a_nxt_s = ~dif.op[0] & dif.a[WIDTH-1];
            sign_b_nxt_s = ~dif.op[0] & dif.b[WIDTH-1];
            state_nxt_s  = S_PREP;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_PREP: begin
          quo_nxt_s = abs_a_s;
          dvs_nxt_s = abs_b_s;
          rem_nxt_s = ZERO;
          cnt_nxt_s = CNT_LAST;
          if (b_r == ZERO) begin
            result_nxt_s = op_r[1] ? a_r : ONES;
            state_nxt_s  = S_DONE;
          end else if (is_signed_s && (a_r == MIN_NEG) && (b_r == ONES)) begin
            result_nxt_s = op_r[1] ? ZERO : MIN_NEG;
            state_nxt_s  = S_DONE;
`ifdef SEQ_DIV_EARLY_OUT_EN
          end else if (abs_a_s < abs_b_s) begin
            result_nxt_s = op_r[1] ? a_r : ZERO;
            state_nxt_s  = S_DONE;
`endif
          end else begin
            state_nxt_s = S_CALC;
          end
        end
        S_CALC: begin
          rem_nxt_s = no_borrow_s ? trial_s[WIDTH-1:0] : rem_sh_s;
          quo_nxt_s = {quo_r[WIDTH-2:0], no_borrow_s};
          if (cnt_r == CNT_ZERO) begin
            state_nxt_s = S_FIX;
          end else begin
            cnt_nxt_s   = cnt_r - CNT_ONE;
            state_nxt_s = S_CALC;
          end
        end
        S_FIX: begin
          result_nxt_s = op_r[1] ? rem_fix_s : quo_fix_s;
          state_nxt_s  = S_DONE;
        end
        S_DONE: begin
          if (dif.out_ready) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_DONE;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= 2'b00;
      a_r         <= ZERO;
      b_r         <= ZERO;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      rem_r       <= ZERO;
      quo_r       <= ZERO;
      dvs_r       <= ZERO;
      cnt_r       <= CNT_ZERO;
      result_r    <= ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      op_r        <= op_nxt_s;
      a_r         <= a_nxt_s;
      b_r         <= b_nxt_s;
      sign_a_r    <= sign_a_nxt_s;
      sign_b_r    <= sign_b_nxt_s;
      rem_r       <= rem_nxt_s;
      quo_r       <= quo_nxt_s;
      dvs_r       <= dvs_nxt_s;
      cnt_r       <= cnt_nxt_s;
      result_r    <= result_nxt_s;
      in_ready_r  <= (state_nxt_s == S_IDLE);
      out_valid_r <= (state_nxt_s == S_DONE);
      busy_r      <= (state_nxt_s != S_IDLE);
    end
  end

  assign dif.in_ready   = in_ready_r;
  assign dif.out_valid  = out_valid_r;
  assign dif.out_result = result_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized + directed bench for seq_divider against an arithmetic
// reference model (RV32M division rules, cycle-count latency).
module tb_seq_divider;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam logic [31:0] ONES    = 32'hFFFF_FFFF;
`ifdef SEQ_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic clk;
  logic rst_n;
  logic kill;
  logic busy;

  seq_divider_if #(.WIDTH(32)) dif ();

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kill  (kill),
    .busy  (busy),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M result from plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    if (y == 32'd0) return o[1] ? x : ONES;
    if (!o[0] && x == MIN_NEG && y == ONES) return o[1] ? 32'd0 : MIN_NEG;
    if (!o[0]) begin
      sx = $signed(x);
      sy = $signed(y);
      return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  // Edges from accept to first out_valid.
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint mx, my;
    if (y == 32'd0) return 1;
    if (!o[0] && x == MIN_NEG && y == ONES) return 1;
    mx = (!o[0] && x[31]) ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
    my = (!o[0] && y[31]) ? (64'h1_0000_0000 - longint'(y)) : longint'(y);
    if (mx < my) return EARLY_LAT;
    return 34;
  endfunction

  logic        m_busy, m_valid;
  int          m_age, m_lat;
  logic [31:0] m_res;

  // Transaction-level model of what the divider must present.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_age   <= 0;
      m_lat   <= 0;
      m_res   <= 32'd0;
    end else if (kill) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!m_busy) begin
      if (dif.in_valid) begin
        m_busy  <= 1'b1;
        m_valid <= 1'b0;
        m_age   <= 0;
        m_lat   <= ref_lat(dif.op, dif.a, dif.b);
        m_res   <= ref_res(dif.op, dif.a, dif.b);
      end
    end else if (m_valid) begin
      if (dif.out_ready) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end
    end else begin
      m_age   <= m_age + 1;
      m_valid <= (m_age + 1 == m_lat);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {31'd0, dif.in_ready}, {31'd0, !m_busy});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("out_valid", {31'd0, dif.out_valid}, {31'd0, m_valid});
      if (m_valid) check("out_result", dif.out_result, m_res);
    end
  end

  // Issue one operation; kill_after>0 flushes after that many edges. lat=-1 if killed.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int kill_after, input int hold,
                        output int lat, output logic [31:0] res);
    int g;
    int n;
    g = 0;
    @(negedge clk);
    while (!dif.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("accept_wait", {31'd0, dif.in_ready}, 32'd1);
    dif.op = o;
    dif.a = x;
    dif.b = y;
    dif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
    dif.op = 2'($urandom);
    dif.a = $urandom;
    dif.b = $urandom;
    n = 0;
    lat = -1;
    res = 32'd0;
    while (!dif.out_valid && n < 100) begin
      if (kill_after != 0 && n == kill_after) begin
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        return;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("timeout", 32'(n), 32'd0);
    lat = n;
    res = dif.out_result;
    repeat (hold) @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic [31:0] res;
    run_op(o, x, y, 0, 1, lat, res);
    check({name, "_res"}, res, exp_res);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int lat;
    logic [31:0] res;
    logic [1:0]  o;
    logic [31:0] x, y;
    int kind;

    rst_n = 1'b0;
    kill = 1'b0;
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b0;
    dif.op = 2'b00;
    dif.a = 32'd0;
    dif.b = 32'd0;
    #12;
    check("rst_in_ready", {31'd0, dif.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_result", dif.out_result, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    directed("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    directed("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34);
    directed("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    directed("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    directed("div_by0", 2'b00, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
    directed("remu_by0", 2'b11, 32'h1234, 32'd0, 32'h1234, 1);
    directed("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    directed("divu_3_10", 2'b01, 32'd3, 32'd10, 32'd0, EARLY_LAT);
    directed("divu_ones_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34);
    directed("divu_ones_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

    // Flush in the middle of CALC; the result must never appear.
    run_op(2'b01, 32'd1000, 32'd3, 10, 0, lat, res);
    check("kill_lat", 32'(lat), 32'hFFFF_FFFF);
    check("kill_in_ready", {31'd0, dif.in_ready}, 32'd1);
    check("kill_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("kill_no_valid", {31'd0, dif.out_valid}, 32'd0);

    // kill wins over an accept in the same cycle.
    dif.op = 2'b01;
    dif.a = 32'd9;
    dif.b = 32'd2;
    dif.in_valid = 1'b1;
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
    kill = 1'b0;
    check("kill_vs_accept_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset during CALC.
    @(negedge clk);
    dif.op = 2'b01;
    dif.a = 32'd12345;
    dif.b = 32'd17;
    dif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, dif.in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, dif.out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_out_result", dif.out_result, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    directed("after_rst_divu", 2'b01, 32'd100, 32'd7, 32'd14, 34);

    for (int i = 0; i < 120; i++) begin
      o = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 7);
      x = $urandom;
      y = $urandom;
      case (kind)
        0: y = 32'd0;
        1: begin x = MIN_NEG; y = ONES; end
        2: begin x = 32'($urandom_range(0, 50)); y = 32'($urandom_range(51, 1000)); end
        3: y = 32'($urandom_range(1, 15));
        4: y = $urandom_range(0, 1) != 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : y;
        default: ;
      endcase
      run_op(o, x, y, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 30) : 0,
             $urandom_range(0, 3), lat, res);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the integer ALU in the execute stage. Each iteration performs one trial subtraction through the core's shared AddAndSub adder/subtractor (Cin=1). The Carry output means "no borrow" and selects whether the partial remainder is restored. Operands arrive on a valid/ready handshake from issue; the result leaves on a valid/ready handshake toward writeback.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operands and op are valid.
- `in_ready`  out  1  divider can accept; high only in IDLE.
- `op`  in  2  encoding: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a`  in  WIDTH  dividend.
- `b`  in  WIDTH  divisor.
- `kill`  in  1  synchronous flush from the pipeline.
- `out_valid`  out  1  result available; high only in DONE.
- `out_ready`  in  1  writeback consumes the result.
- `out_result`  out  WIDTH  quotient or remainder, per the latched op.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- **IDLE:**
  - Accept on `in_valid & in_ready`.
  - Latch `op`, `a`, `b`, and the signs. Signs are the MSBs for DIV/REM and 0 for unsigned ops.
  - Go to PREP.
- **PREP:** compute the magnitudes |a| and |b|, clear the remainder register, set the iteration counter to WIDTH-1. The next state is:
  - **Divide-by-zero (b==0):** quotient = all-ones, remainder = a. Go to DONE.
  - **Signed overflow (DIV/REM, a==0x8000_0000, b==0xFFFF_FFFF):** quotient = 0x8000_0000, remainder = 0. Go to DONE.
  - **Early-out (`SEQ_DIV_EARLY_OUT_EN` only):** if |a| < |b| unsigned, quotient = 0 and remainder = a. Go to DONE.
  - Otherwise go to CALC.
- **CALC (one iteration per cycle):**
  - Shift {rem, quo} left by 1.
  - Trial = shifted rem − |b|.
  - If Carry=1 (no borrow), rem ← Result and quo LSB ← 1; otherwise keep rem and set quo LSB ← 0.
  - When counter==0, go to FIX; otherwise decrement.
- **FIX:**
  - Negate quo if sign_a≠sign_b.
  - Negate rem if sign_a=1.
  - Go to DONE.
- **DONE:**
  - Hold `out_result` stable.
  - On `out_ready`, go to IDLE.
  - `out_result` is the quotient for DIV/DIVU and the remainder for REM/REMU.
- **`kill`:** in any state, go to IDLE next edge and drop the result. `kill` takes priority over an `out_ready` handshake or an `in_valid` acceptance in the same cycle.
- **Arithmetic:** all at WIDTH bits. Negation is two's complement with wrap. |0x8000_0000| stays 0x8000_0000, interpreted as unsigned.

## Timing
- **Reset (`rst_n`=0):**
  - State = IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `out_result`=0; counter and datapath registers = 0.
  - Reset mid-operation abandons the operation immediately.
- **Normal latency:** with the accept at edge E0, PREP is E0→E1, CALC spans E1→E33 (WIDTH cycles), FIX is E33→E34. `out_valid` is high from E34, i.e. WIDTH+2 edges after the accept.
- **Fast paths** (zero, overflow, early-out): `out_valid` is high from E1.
- **Back-to-back:** the DONE→IDLE handshake edge frees the divider, and the next accept is possible one cycle later. There is no accept in the handshake cycle itself.
- **Output stability:** `out_valid` stays high and `out_result` stays constant until `out_ready` or `kill`.
- **Input sampling:** `a`, `b` and `op` are sampled only at the accept edge; later changes are ignored.

## Configuration
- `SEQ_DIV_EARLY_OUT_EN` defined: the PREP magnitude compare is compiled in. When |a| < |b| the result is produced in 1 cycle.
- Undefined: no comparator. Every non-special operation takes the full WIDTH+2 cycles, and results are identical to the defined case.

## Test plan
- DIVU a=100, b=7, `out_ready`=1 → `out_result`=14, `out_valid` at E34. REMU with the same operands → 2.
- DIV a=−7 (0xFFFF_FFF9), b=2 → 0xFFFF_FFFD (−3). REM with the same operands → 0xFFFF_FFFF (−1).
- DIV with b=0 → 0xFFFF_FFFF. REMU a=0x1234, b=0 → 0x1234. Both at E1.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → 0x8000_0000. REM with the same operands → 0. Both at E1.
- DIVU a=3, b=10 → 0: at E1 with `SEQ_DIV_EARLY_OUT_EN` defined, at E34 without it.
- Assert `kill` in CALC cycle 10 → IDLE next edge and `out_valid` never rises. Then assert `rst_n`=0 mid-CALC → all outputs return to their reset values asynchronously.
